// File: rtl/sb_pkg.sv
// Shared types and default latencies for the issue scheduler and its writeback tracker.
package sb_pkg;

    typedef enum logic [1:0] {
        UNIT_ALU   = 2'b00,
        UNIT_LOAD  = 2'b01,
        UNIT_STORE = 2'b10,
        UNIT_MUL   = 2'b11
    } unit_t;

    localparam int unsigned DEF_LAT_ALU  = 1;
    localparam int unsigned DEF_LAT_LOAD = 2;
    localparam int unsigned DEF_LAT_MUL  = 4;

    // STORE has no result; it falls back to the ALU latency for port bookkeeping.
    function automatic int unsigned lat_of(unit_t u,
                                           int unsigned la = DEF_LAT_ALU,
                                           int unsigned ll = DEF_LAT_LOAD,
                                           int unsigned lm = DEF_LAT_MUL);
        lat_of = la;
        case (u)
            UNIT_LOAD: lat_of = ll;
            UNIT_MUL:  lat_of = lm;
            default:   lat_of = la;
        endcase
    endfunction

endpackage

// File: rtl/sb_wb_tracker.sv
// Shared writeback port reservation: shift vector of booked slots with the rd tag of each slot.
module sb_wb_tracker
    import sb_pkg::*;
#(
    parameter int unsigned SBW = 5,
    parameter int unsigned LW  = $clog2(SBW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          res_en,
    input  logic [LW-1:0] res_slot,
    input  logic [4:0]    res_rd,
    input  logic [LW-1:0] probe,
    output logic          busy,
    output logic          wb_valid,
    output logic [4:0]    wb_rd
);

    logic [SBW-1:0] wb_res;
    logic [SBW-1:0] res_bit;
    logic [4:0]     tag [SBW];

    assign res_bit = res_en ? (SBW'(1) << res_slot) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_res <= '0;
            for (int unsigned i = 0; i < SBW; i++) tag[i] <= '0;
        end else begin
            wb_res <= (wb_res >> 1) | res_bit;
            for (int unsigned i = 0; i < SBW - 1; i++) tag[i] <= tag[i+1];
            tag[SBW-1] <= '0;
            if (res_en) tag[res_slot] <= res_rd;
        end
    end

    // probe is checked one slot above the booking slot because the vector shifts on the same edge
    assign busy     = wb_res[probe];
    assign wb_valid = wb_res[0];
    assign wb_rd    = tag[0];

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue scheduler with per-register latency countdowns and a single shared writeback port.
// Optional FORWARDING_EN: a source written back this cycle is not treated as a RAW hazard.
module issue_scheduler
    import sb_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned SBW      = 5,
    parameter int unsigned LAT_ALU  = DEF_LAT_ALU,
    parameter int unsigned LAT_LOAD = DEF_LAT_LOAD,
    parameter int unsigned LAT_MUL  = DEF_LAT_MUL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [1:0]      id_unit,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_wr_rd,
    input  logic            flush,
    output logic            iss_valid,
    output logic [1:0]      iss_unit,
    output logic [4:0]      iss_rd,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [0:NREG-1] pendente
);

    localparam int unsigned LW = $clog2(SBW);

    unit_t          unit;
    logic [LW-1:0]  lat;
    logic [LW-1:0]  slot;
    logic           wr_eff;
    logic           raw_hz, waw_hz, struct_hz, port_busy;
    logic           issue, set_rd;
    logic [NREG-1:0] blocking;
    logic [SBW-1:0] avail [NREG];

    assign unit   = unit_t'(id_unit);
    assign lat    = LW'(lat_of(unit, LAT_ALU, LAT_LOAD, LAT_MUL));
    assign slot   = lat - LW'(1);
    assign wr_eff = id_wr_rd & (unit != UNIT_STORE);

    always_comb begin
        pendente = '0;
        blocking = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pendente[r] = |avail[r];
`ifdef FORWARDING_EN
            blocking[r] = pendente[r] & (avail[r] != SBW'(1));
`else
            blocking[r] = pendente[r];
`endif
        end
    end

    assign raw_hz    = blocking[id_rs1] | (id_use_rs2 & blocking[id_rs2]);
    assign waw_hz    = wr_eff & pendente[id_rd];
    assign struct_hz = wr_eff & port_busy;
    assign id_ready  = !raw_hz && !waw_hz && !struct_hz && !flush;
    assign issue     = id_valid & id_ready;
    assign set_rd    = issue & wr_eff & (id_rd != '0);

    sb_wb_tracker #(.SBW(SBW), .LW(LW)) u_wb (
        .clk      (clk),
        .rst      (rst),
        .res_en   (set_rd),
        .res_slot (slot),
        .res_rd   (id_rd),
        .probe    (lat),
        .busy     (port_busy),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++) avail[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) avail[r] <= avail[r] >> 1;
            if (set_rd) avail[id_rd] <= SBW'(1) << slot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid <= 1'b0;
            iss_unit  <= '0;
            iss_rd    <= '0;
        end else begin
            iss_valid <= issue;
            if (issue) begin
                iss_unit <= id_unit;
                iss_rd   <= id_rd;
            end
        end
    end

endmodule
